// File: rtl/serial_full_adder.sv
// Digit-serial adder/subtractor: DIGIT full-adder cells per cycle, LSB digit first,
// with a registered carry and a start/ready/done handshake.
module serial_full_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("serial_full_adder: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
    logic             carry_q, carry_d, c;
    logic [DIGIT-1:0] dsum;
    logic [CW-1:0]    count;
    logic             last;
    logic             accept;

    assign ready  = (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = start && (state != RUN);
    assign last   = (count == CW'(N - 1));

    // Ripple through the DIGIT cells of the current digit; b_q already holds B or ~B.
    always_comb begin
        dsum = '0;
        c    = carry_q;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            dsum[i] = a_q[i] ^ b_q[i] ^ c;
            c       = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        carry_d  = c;
        // New digit enters at the top; after N digits the first one sits at the LSB.
        res_next = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        state_next = last ? DONE : RUN;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            count   <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q     <= A;
                b_q     <= Sub ? ~B : B;
                carry_q <= Sub ^ Cin;
                count   <= '0;
            end else if (state == RUN) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                res_q   <= res_next;
                carry_q <= carry_d;
                count   <= count + CW'(1);
                if (last) begin
                    Sum  <= res_next;
                    Cout <= carry_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: three instances (8/1, 1/1, 8/4) checked
// against an arithmetic reference model with randomized and directed operands.
module tb_serial_full_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = '0;
    logic [2:0] sub = '0;
    logic [2:0] cin = '0;
    logic [7:0] a [3];
    logic [7:0] b [3];
    logic [2:0] ready, busy, done, cout;
    logic [7:0] sum0, sum2;
    logic       sum1;

    logic [8:0] exp_prev [3];
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    serial_full_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .start(start[0]), .Sub(sub[0]), .A(a[0]), .B(b[0]),
        .Cin(cin[0]), .ready(ready[0]), .busy(busy[0]), .done(done[0]), .Sum(sum0), .Cout(cout[0])
    );

    serial_full_adder #(.WIDTH(1), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .Sub(sub[1]), .A(a[1][0:0]), .B(b[1][0:0]),
        .Cin(cin[1]), .ready(ready[1]), .busy(busy[1]), .done(done[1]), .Sum(sum1), .Cout(cout[1])
    );

    serial_full_adder #(.WIDTH(8), .DIGIT(4)) u4 (
        .clk(clk), .rst(rst), .start(start[2]), .Sub(sub[2]), .A(a[2]), .B(b[2]),
        .Cin(cin[2]), .ready(ready[2]), .busy(busy[2]), .done(done[2]), .Sum(sum2), .Cout(cout[2])
    );

    function automatic int width_of(input int sel);
        return (sel == 1) ? 1 : 8;
    endfunction

    function automatic int n_of(input int sel);
        case (sel)
            0:       return 8;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [8:0] obs(input int sel);
        case (sel)
            0:       return {cout[0], sum0};
            1:       return {cout[1], 7'd0, sum1};
            default: return {cout[2], sum2};
        endcase
    endfunction

    // Reference: plain integer add, or A-B-Cin with "no borrow" as the carry flag.
    function automatic logic [8:0] model(input int w, input logic s, input logic [7:0] av,
                                         input logic [7:0] bv, input logic c);
        int unsigned m, x, y, r;
        logic        co;
        m = 32'd1 << w;
        x = av % m;
        y = bv % m;
        if (!s) begin
            r  = x + y + c;
            co = (r >= m);
        end else begin
            r  = x + m - y - c;
            co = (x >= y + c);
        end
        return {co, 8'(r % m)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_prev[i] = '0;
    endtask

    task automatic run_op(input int sel, input logic s, input logic [7:0] av, input logic [7:0] bv,
                          input logic c, input logic pulse, input string name);
        logic [8:0] e;
        int         n, k;
        e = model(width_of(sel), s, av, bv, c);
        n = n_of(sel);
        k = 0;
        @(negedge clk);
        start[sel] = 1'b1; sub[sel] = s; a[sel] = av; b[sel] = bv; cin[sel] = c;
        n_checks++;
        if (ready[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, ready[sel]);
        end
        @(posedge clk);
        @(negedge clk);
        start[sel] = pulse;
        a[sel] = 8'($urandom); b[sel] = 8'($urandom);
        cin[sel] = 1'($urandom); sub[sel] = 1'($urandom);
        n_checks++;
        if (busy[sel] !== 1'b1 || obs(sel) !== exp_prev[sel]) begin
            n_fail++;
            $display("FAIL %s run_hold: busy=%b result=%h want busy=1 result=%h",
                     name, busy[sel], obs(sel), exp_prev[sel]);
        end
        for (int i = 1; i <= n + 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            start[sel] = 1'b0;
            if (done[sel] === 1'b1) begin
                k = i;
                break;
            end
        end
        n_checks++;
        if (k != n) begin
            n_fail++;
            $display("FAIL %s latency: done after %0d edges want %0d", name, k, n);
        end
        n_checks++;
        if (obs(sel) !== e) begin
            n_fail++;
            $display("FAIL %s result: got {Cout,Sum}=%h want %h", name, obs(sel), e);
        end
        exp_prev[sel] = e;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done[sel] !== 1'b0 || ready[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s single_pulse: done=%b ready=%b want done=0 ready=1",
                     name, done[sel], ready[sel]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ready[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0 || obs(i) !== 9'h000) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: ready=%b busy=%b done=%b result=%h want 1 0 0 000",
                         i, ready[i], busy[i], done[i], obs(i));
            end
        end
    endtask

    task automatic test_exhaustive_1bit();
        for (int i = 0; i < 8; i++) begin
            run_op(1, 1'b0, {7'd0, i[2]}, {7'd0, i[1]}, i[0], 1'b0, "fa1_truth");
        end
        for (int i = 0; i < 4; i++) begin
            run_op(1, 1'b1, {7'd0, i[1]}, {7'd0, i[0]}, 1'b0, 1'b0, "fa1_sub");
        end
    endtask

    task automatic test_add_wrap();
        run_op(0, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    endtask

    task automatic test_subtract();
        run_op(0, 1'b1, 8'h05, 8'h07, 1'b0, 1'b0, "sub_5_7");
        run_op(0, 1'b1, 8'h07, 8'h05, 1'b0, 1'b0, "sub_7_5");
        run_op(0, 1'b1, 8'h07, 8'h07, 1'b1, 1'b0, "sub_borrow_in");
    endtask

    task automatic test_digit4();
        run_op(2, 1'b0, 8'h9C, 8'h6B, 1'b1, 1'b1, "d4_start_in_run");
        for (int i = 0; i < 6; i++) begin
            run_op(2, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "d4_random");
        end
    endtask

    task automatic test_random_d1();
        for (int i = 0; i < 8; i++) begin
            run_op(0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "d1_random");
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        pulses = 0;
        @(negedge clk);
        start[0] = 1'b1; sub[0] = 1'b0; a[0] = 8'h5A; b[0] = 8'h33; cin[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_prev[i] = '0;
        n_checks++;
        if (obs(0) !== 9'h000 || done[0] !== 1'b0 || ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_run: result=%h done=%b ready=%b want 000 0 1",
                     obs(0), done[0], ready[0]);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done[0] === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL rst_no_done: got %0d done pulses want 0", pulses);
        end
        run_op(0, 1'b0, 8'h10, 8'h20, 1'b0, 1'b0, "after_rst_add");
    endtask

    task automatic test_back_to_back();
        localparam int K = 5;
        logic       s_q [$];
        logic [7:0] a_q [$];
        logic [7:0] b_q [$];
        logic       c_q [$];
        logic [8:0] e;
        int         k;
        for (int j = 0; j < K; j++) begin
            s_q.push_back(1'($urandom)); a_q.push_back(8'($urandom));
            b_q.push_back(8'($urandom)); c_q.push_back(1'($urandom));
        end
        @(negedge clk);
        start[0] = 1'b1; sub[0] = s_q[0]; a[0] = a_q[0]; b[0] = b_q[0]; cin[0] = c_q[0];
        @(posedge clk);
        for (int j = 0; j < K; j++) begin
            e = model(8, s_q[j], a_q[j], b_q[j], c_q[j]);
            @(negedge clk);
            a[0] = 8'($urandom); b[0] = 8'($urandom); cin[0] = 1'($urandom); sub[0] = 1'($urandom);
            k = 0;
            for (int i = 1; i <= 11; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (done[0] === 1'b1) begin
                    k = i;
                    break;
                end
            end
            n_checks++;
            if (k != 8 || ready[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_timing[%0d]: done after %0d edges ready=%b want 8 edges ready=1",
                         j, k, ready[0]);
            end
            n_checks++;
            if (obs(0) !== e) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got %h want %h", j, obs(0), e);
            end
            exp_prev[0] = e;
            if (j < K - 1) begin
                sub[0] = s_q[j+1]; a[0] = a_q[j+1]; b[0] = b_q[j+1]; cin[0] = c_q[j+1];
            end else begin
                start[0] = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: done=%b busy=%b want 0 0", done[0], busy[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            b[i] = '0;
            exp_prev[i] = '0;
        end
        test_reset();
        test_exhaustive_1bit();
        test_add_wrap();
        test_subtract();
        test_digit4();
        test_random_d1();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
